// File: rtl/mc_ctrl_pkg.sv
// Package: mc_ctrl_pkg
// Shared definitions for the multi-cycle RV32 sequencer (mc_ctrl_fsm) and its
// wait timer: the state encoding, the PC-select and write-back-select codes,
// and the decoder's jump-indicator codes.
//
// Optional feature macro used by the sequencer: MC_CTRL_PERF_EN.

package mc_ctrl_pkg;

    // The encoding is visible on state_o, so the values are fixed.
    // Encoding 6 is unused and is treated as an error.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd7
    } state_e;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;   // pc + 4
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;   // pc + imm (branch / JAL)
    localparam logic [1:0] PC_SEL_JALR   = 2'b10;   // (rs1 + imm) & ~1

    // Register-file write-data source
    localparam logic [1:0] WB_SEL_ALU    = 2'b00;
    localparam logic [1:0] WB_SEL_MEM    = 2'b01;
    localparam logic [1:0] WB_SEL_LINK   = 2'b10;   // pc + 4

    // Decoder jump indicator
    localparam logic [1:0] JUMPI_NONE    = 2'b00;
    localparam logic [1:0] JUMPI_JAL     = 2'b01;
    localparam logic [1:0] JUMPI_JALR    = 2'b10;

    // Busy covers every state in which an instruction is in flight.
    function automatic logic state_is_busy(input state_e st);
        return (st != ST_IDLE) && (st != ST_ERR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Module: mc_wait_timer
// Counts the cycles a memory request has been waiting for its rvalid.
// One instance serves both the instruction fetch and the data access, since
// only one of them can be outstanding at a time.
//
// Ports:
//   clk       in  1  clock
//   rst_n     in  1  asynchronous reset, active-low
//   clr_i     in  1  clear the count (takes priority over en_i)
//   en_i      in  1  count this cycle (request pending, no rvalid)
//   expire_o  out 1  count has reached MAX_WAIT-1
//
// Parameter MAX_WAIT (>=2): the request is allowed MAX_WAIT cycles in total;
// expire_o is raised during the last of them.

module mc_wait_timer #(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign expire_o = (cnt_q == LIMIT);

    // Saturates at LIMIT: the sequencer leaves the waiting state on expiry,
    // so holding the value just avoids a meaningless wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Module: mc_ctrl_fsm
// Multi-cycle sequencer for the RV32 core. Walks each instruction through
// FETCH / DECODE / EXEC / MEM / WB using the decoder control bits, drives the
// IR, PC, register-file and data-memory enables, and owns the instruction and
// data memory request handshakes. A request that waits MAX_WAIT cycles without
// rvalid sends the sequencer into a sticky ERR state that only rst_n leaves.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 level-sensitive run enable
//   imem_req/imem_rvalid  instruction fetch handshake
//   dmem_req/dmem_we/dmem_rvalid  data access handshake (we: 1=store)
//   dec_*                 decoder control bits; dec_jumpi 01=JAL, 10=JALR
//   br_taken              branch comparison result, valid in EXEC
//   ir_we, pc_we, pc_sel  instruction register / PC update controls
//   rf_we, wb_sel         register-file write controls
//   state_o, busy, err    status
//   retire                one-cycle pulse per completed instruction
//   cycle_cnt, instret_cnt  performance counters (PERF_W bits)
//
// Configuration macro MC_CTRL_PERF_EN: when defined, cycle_cnt counts busy
// cycles and instret_cnt counts retired instructions (both wrap). When not
// defined the counters are not built and both ports read 0.
//
// All enables are combinational from the state register and inputs, so an
// asynchronous reset drops requests immediately.

module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    input  logic              imem_rvalid,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_rvalid,
    input  logic              dec_branch,
    input  logic              dec_memread,
    input  logic              dec_memtoreg,
    input  logic              dec_memwrite,
    input  logic              dec_regwrite,
    input  logic [1:0]        dec_jumpi,
    input  logic              dec_illegal,
    input  logic              br_taken,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic [2:0]        state_o,
    output logic              busy,
    output logic              err,
    output logic              retire,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
);

    state_e state_q, state_d;
    logic   wait_en;
    logic   wait_expire;
    logic   do_retire;

    // Any state change restarts the wait count, which covers entry to both
    // FETCH and MEM without tracking which one is being entered.
    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_d != state_q),
        .en_i     (wait_en),
        .expire_o (wait_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_SEL_PLUS4;
        rf_we     = 1'b0;
        wb_sel    = WB_SEL_ALU;
        wait_en   = 1'b0;
        do_retire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                wait_en  = !imem_rvalid;
                // rvalid in the expiry cycle still completes the fetch
                if (imem_rvalid) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expire) begin
                    state_d = ST_ERR;
                end
            end

            ST_DECODE: begin
                state_d = dec_illegal ? ST_ERR : ST_EXEC;
            end

            ST_EXEC: begin
                if (dec_jumpi == JUMPI_JAL) begin
                    pc_sel    = PC_SEL_BRANCH;
                    wb_sel    = WB_SEL_LINK;
                    rf_we     = 1'b1;
                    pc_we     = 1'b1;
                    do_retire = 1'b1;
                end else if (dec_jumpi == JUMPI_JALR) begin
                    pc_sel    = PC_SEL_JALR;
                    wb_sel    = WB_SEL_LINK;
                    rf_we     = 1'b1;
                    pc_we     = 1'b1;
                    do_retire = 1'b1;
                end else if (dec_branch) begin
                    pc_sel    = br_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                    pc_we     = 1'b1;
                    do_retire = 1'b1;
                end else if (dec_memread || dec_memwrite) begin
                    state_d = ST_MEM;
                end else if (dec_regwrite) begin
                    state_d = ST_WB;
                end else begin
                    pc_we     = 1'b1;
                    do_retire = 1'b1;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memwrite;
                wait_en  = !dmem_rvalid;
                if (dmem_rvalid) begin
                    // Loads always write back, whatever dec_regwrite says.
                    if (dec_memread) begin
                        state_d = ST_WB;
                    end else begin
                        pc_we     = 1'b1;
                        do_retire = 1'b1;
                    end
                end else if (wait_expire) begin
                    state_d = ST_ERR;
                end
            end

            ST_WB: begin
                rf_we     = 1'b1;
                wb_sel    = dec_memtoreg ? WB_SEL_MEM : WB_SEL_ALU;
                pc_we     = 1'b1;
                do_retire = 1'b1;
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_ERR;
            end
        endcase

        // start is only sampled at the end of an instruction, so dropping it
        // never aborts one in flight.
        if (do_retire) begin
            state_d = start ? ST_FETCH : ST_IDLE;
        end
    end

    assign retire  = do_retire;
    assign state_o = state_q;
    assign busy    = state_is_busy(state_q);
    assign err     = (state_q == ST_ERR);

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] cycle_cnt_q;
    logic [PERF_W-1:0] instret_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            if (busy) begin
                cycle_cnt_q <= cycle_cnt_q + PERF_W'(1);
            end
            if (do_retire) begin
                instret_cnt_q <= instret_cnt_q + PERF_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
